// File: rtl/td4_core_param.sv
// td4_core_param: parametrised TD4 CPU datapath with clock-enable stepping,
// a two-flop input synchroniser and sticky self-loop halt detection.
module td4_core_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              clr_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_port,
  input  logic [DATA_W+3:0] instr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out_port,
  output logic              carry,
  output logic              halted
);
  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d, s1_q, s2_q, im;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt;
  logic [DATA_W:0]   sum_a, sum_b;
  logic [3:0]        op;
  logic              c_q, c_d, h_q, h_d, take;
  always_comb begin
    op = instr[DATA_W+3:DATA_W];
    im = instr[DATA_W-1:0];
    sum_a = {1'b0, a_q} + {1'b0, im};
    sum_b = {1'b0, b_q} + {1'b0, im};
    tgt = im[ADDR_W-1:0];
    // JNC looks at the carry left by the previous instruction
    take = (op == OP_JMP) || (op == OP_JNC && !c_q);
    pc_d = take ? tgt : pc_q + ADDR_W'(1);
    a_d = op == OP_ADD_A  ? sum_a[DATA_W-1:0] :
          op == OP_MOV_AI ? im :
          op == OP_MOV_AB ? b_q :
          op == OP_IN_A   ? s2_q : a_q;
    b_d = op == OP_ADD_B  ? sum_b[DATA_W-1:0] :
          op == OP_MOV_BI ? im :
          op == OP_MOV_BA ? a_q :
          op == OP_IN_B   ? s2_q : b_q;
    out_d = op == OP_OUT_B ? b_q : op == OP_OUT_I ? im : out_q;
    c_d = op == OP_ADD_A ? sum_a[DATA_W] : op == OP_ADD_B ? sum_b[DATA_W] : 1'b0;
    h_d = h_q | (take && tgt == pc_q);
  end
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= '0;
      c_q   <= 1'b0;
      h_q   <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      if (en) begin
        a_q   <= a_d;
        b_q   <= b_d;
        out_q <= out_d;
        pc_q  <= pc_d;
        c_q   <= c_d;
        h_q   <= h_d;
      end
    end
  end
  assign addr     = pc_q;
  assign out_port = out_q;
  assign carry    = c_q;
  assign halted   = h_q;
endmodule

// File: tb/tb_td4_core_param.sv
// tb_td4_core_param: vector tables run through an expected-result queue against
// a 4/4 and an 8/5 instance, each fed by a small asynchronous ROM.
module tb_td4_core_param;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic        clr_n, en, clr8_n, en8, carry, halted, carry8, halted8;
  logic [3:0]  in_port, addr, out_port;
  logic [7:0]  in8, out8, instr;
  logic [4:0]  addr8;
  logic [11:0] instr8;
  logic [7:0]  rom [16];
  logic [11:0] rom8 [32];
  always_comb instr = rom[addr];
  always_comb instr8 = rom8[addr8];
  td4_core_param #(.DATA_W(4), .ADDR_W(4)) u4 (
    .CLK(CLK), .clr_n(clr_n), .en(en), .in_port(in_port), .instr(instr),
    .addr(addr), .out_port(out_port), .carry(carry), .halted(halted));
  td4_core_param #(.DATA_W(8), .ADDR_W(5)) u8 (
    .CLK(CLK), .clr_n(clr8_n), .en(en8), .in_port(in8), .instr(instr8),
    .addr(addr8), .out_port(out8), .carry(carry8), .halted(halted8));
  typedef struct {bit w; bit e; int inp; int a; int o; int c; int h;} vec_t;
  typedef struct {int a; int o; int c; int h;} exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  int total = 0, bad = 0;
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input string nm);
    exp_t x;
    if (v.w) en8 = v.e;
    else begin
      en = v.e;
      in_port = v.inp[3:0];
    end
    sb.push_back('{v.a, v.o, v.c, v.h});
    @(posedge CLK);
    #1;
    x = sb.pop_front();
    check({nm, " addr"}, v.w ? int'(addr8) : int'(addr), x.a);
    check({nm, " out"}, v.w ? int'(out8) : int'(out_port), x.o);
    check({nm, " carry"}, v.w ? int'(carry8) : int'(carry), x.c);
    check({nm, " halted"}, v.w ? int'(halted8) : int'(halted), x.h);
  endtask
  task automatic run(input string nm);
    foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
  endtask
  task automatic check_zero(input string nm);
    check({nm, " addr"}, int'(addr), 0);
    check({nm, " out"}, int'(out_port), 0);
    check({nm, " carry"}, int'(carry), 0);
    check({nm, " halted"}, int'(halted), 0);
  endtask
  task automatic mid_reset(input string nm);
    #3 clr_n = 1'b0;
    #1 check_zero(nm);
    foreach (rom[i]) rom[i] = 8'h80;
  endtask
  initial begin
    clr_n = 1'b0; en = 1'b0; in_port = '0;
    clr8_n = 1'b0; en8 = 1'b0; in8 = '0;
    foreach (rom[i]) rom[i] = 8'h80;
    foreach (rom8[i]) rom8[i] = 12'h800;
    #1 check_zero("reset");
    // carry out of ADD, JNC not taken then taken, en gating
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0; rom[3] = 8'hB7;
    rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hE9; rom[9] = 8'hB5;
    @(posedge CLK); #1 clr_n = 1'b1;
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 2, 0, 1, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 0, 2, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 3, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 4, 7, 0, 0});
    tbl.push_back('{0, 1, 0, 5, 7, 0, 0});
    tbl.push_back('{0, 1, 0, 6, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 9, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 10, 5, 0, 0});
    run("add");
    mid_reset("midrst1");
    // MOV/OUT path, ADD B carry, PC wrap
    rom[0] = 8'h3A; rom[1] = 8'h40; rom[2] = 8'h90; rom[3] = 8'h57; rom[4] = 8'h90;
    @(posedge CLK); #1 clr_n = 1'b1;
    tbl.push_back('{0, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 2, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 3, 10, 0, 0});
    tbl.push_back('{0, 1, 0, 4, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 5, 1, 0, 0});
    for (int i = 6; i <= 17; i++) tbl.push_back('{0, 1, 0, i % 16, 1, 0, 0});
    run("mov");
    #3 clr_n = 1'b0;
    // synchroniser latency, then halt on a self-jump
    foreach (rom[i]) rom[i] = 8'h80;
    rom[0] = 8'h20; rom[1] = 8'h60; rom[2] = 8'h90; rom[3] = 8'h20;
    rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hF6;
    in_port = 4'h9;
    @(posedge CLK); #1 clr_n = 1'b1;
    tbl.push_back('{0, 0, 9, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 9, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 6, 1, 0, 0, 0});
    tbl.push_back('{0, 1, 6, 2, 0, 0, 0});
    tbl.push_back('{0, 1, 6, 3, 9, 0, 0});
    tbl.push_back('{0, 1, 6, 4, 9, 0, 0});
    tbl.push_back('{0, 1, 6, 5, 9, 0, 0});
    tbl.push_back('{0, 1, 6, 6, 6, 0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 1, 6, 6, 6, 0, 1});
    run("inhalt");
    mid_reset("midrst2");
    // wide instance: 8-bit carry, upper jump bits ignored, JNC self-loop
    rom8[0] = 12'h3FF; rom8[1] = 12'h001; rom8[2] = 12'hFE4;
    rom8[4] = 12'h140; rom8[5] = 12'h900; rom8[6] = 12'hE26;
    @(posedge CLK); #1 clr8_n = 1'b1;
    tbl.push_back('{1, 1, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 2, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 4, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 5, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 6, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 6, 0, 0, 1});
    tbl.push_back('{1, 1, 0, 6, 0, 0, 1});
    run("wide");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
